// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and helpers for the SPI register-bank slave
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        OVER = 2'd3
    } state_t;

    // Bits in one complete frame: R/W flag, address, data.
    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    // Sample on the rising sclk edge when CPOL and CPHA agree (modes 0 and 3),
    // otherwise on the falling edge; the launch edge is always the other one.
    function automatic bit sample_on_rise(input bit cpol, input bit cpha);
        return (cpol == cpha);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop input synchronizer with rise/fall pulse outputs
module sync_edge_det #(
    parameter int STAGES    = 2,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Shift the raw pin through the synchronizer and keep one delayed copy for edges.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise =  o_q & ~r_prev;
    assign o_fall = ~o_q &  r_prev;

endmodule

// File: rtl/spi_slave_regif.sv
// rtl/spi_slave_regif.sv - framed SPI slave driving register-bank write/read strobes
module spi_slave_regif
    import spi_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sclk,
    input  logic              i_mosi,
    input  logic              i_ss,
    output logic              o_miso,
    output logic              o_miso_oe,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_rd_req,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_rd_valid,
    output logic              o_frame_start,
    output logic              o_frame_end,
    output logic              o_frame_err,
    output logic              o_busy
);

    localparam int FRAME_W     = frame_w(ADDR_W, DATA_W);
    localparam int CNT_W       = $clog2(FRAME_W + 2);
    localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
    localparam logic [CNT_W-1:0] CNT_LAST_ADDR = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_LAST_DATA = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT       = CNT_W'(FRAME_W + 1);

    logic w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic w_ss_q, w_ss_rise, w_ss_fall;
    logic w_mosi, w_sample, w_launch, w_bit, w_data_launch, w_take;
    logic [FRAME_W-2:0] w_sr_next;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rw;
    logic [FRAME_W-2:0] r_sr;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic               r_frame_start, r_frame_end, r_frame_err;
    logic               r_wr_en, r_rd_req;
    logic [ADDR_W-1:0]  r_wr_addr, r_rd_addr;
    logic [DATA_W-1:0]  r_wr_data, r_miso_sr;
    logic               r_miso, r_loaded, r_launched, r_late;

    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_sclk),
        .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_ss),
        .o_q(w_ss_q), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    // mosi gets the same latency as sclk so it lines up with the sample pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_mosi_sync <= '0;
        else       r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
    end

    assign w_mosi        = r_mosi_sync[SYNC_STAGES-1];
    assign w_sample      = (w_sclk_rise | w_sclk_fall) & (w_sclk_q == SAMPLE_RISE);
    assign w_launch      = (w_sclk_rise | w_sclk_fall) & (w_sclk_q != SAMPLE_RISE);
    assign w_bit         = w_sample & ~w_ss_q & (r_state != IDLE);
    assign w_data_launch = w_launch & ~w_ss_q & (r_state == DATA);
    assign w_take        = i_rd_valid & r_rw & (r_state == DATA) & ~r_loaded & ~r_launched;
    assign w_sr_next     = {r_sr[FRAME_W-3:0], w_mosi};

    // Frame FSM: bit counting, address/data capture and all strobes toward the bank.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_rw          <= 1'b0;
            r_sr          <= '0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_frame_err   <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_rd_req      <= 1'b0;
            r_rd_addr     <= '0;
        end else begin
            r_frame_start <= w_ss_fall;
            r_frame_end   <= w_ss_rise;
            r_frame_err   <= 1'b0;
            r_wr_en       <= 1'b0;
            r_rd_req      <= 1'b0;
            if (w_ss_rise) begin
                // End of frame wins over a coincident sample; that bit is dropped.
                r_state <= IDLE;
                if (r_state != IDLE) begin
                    if (r_cnt != CNT_FULL || r_late) begin
                        r_frame_err <= 1'b1;
                    end else if (!r_rw) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_sr[FRAME_W-2 -: ADDR_W];
                        r_wr_data <= r_sr[DATA_W-1:0];
                    end
                end
            end else if (w_ss_fall) begin
                r_state <= ADDR;
                r_cnt   <= '0;
                r_rw    <= 1'b0;
            end else if (w_bit) begin
                if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
                if (r_cnt == '0)          r_rw <= w_mosi;
                else if (r_cnt < CNT_FULL) r_sr <= w_sr_next;
                case (r_state)
                    ADDR: if (r_cnt == CNT_LAST_ADDR) begin
                        r_state <= DATA;
                        if (r_rw) begin
                            r_rd_req  <= 1'b1;
                            r_rd_addr <= w_sr_next[ADDR_W-1:0];
                        end
                    end
                    DATA: if (r_cnt == CNT_LAST_DATA) r_state <= OVER;
                    default: ;
                endcase
            end
        end
    end

    // Read data path: load once before the first data launch, then shift out MSB first.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_miso     <= 1'b0;
            r_miso_sr  <= '0;
            r_loaded   <= 1'b0;
            r_launched <= 1'b0;
            r_late     <= 1'b0;
        end else if (w_ss_fall) begin
            r_miso     <= 1'b0;
            r_miso_sr  <= '0;
            r_loaded   <= 1'b0;
            r_launched <= 1'b0;
            r_late     <= 1'b0;
        end else if (w_data_launch) begin
            r_launched <= 1'b1;
            if (!r_launched && !r_loaded) begin
                if (w_take) begin
                    // Data arriving on the deadline cycle still drives its MSB.
                    r_miso    <= i_rd_data[DATA_W-1];
                    r_miso_sr <= {i_rd_data[DATA_W-2:0], 1'b0};
                    r_loaded  <= 1'b1;
                end else begin
                    r_miso <= 1'b0;
                    r_late <= r_rw;
                end
            end else begin
                r_miso    <= r_miso_sr[DATA_W-1];
                r_miso_sr <= {r_miso_sr[DATA_W-2:0], 1'b0};
            end
        end else begin
            if (w_take) begin
                r_miso_sr <= i_rd_data;
                r_loaded  <= 1'b1;
            end
            if (r_state != DATA) r_miso <= 1'b0;
        end
    end

    assign o_miso        = r_miso;
    assign o_miso_oe     = ~w_ss_q;
    assign o_wr_en       = r_wr_en;
    assign o_wr_addr     = r_wr_addr;
    assign o_wr_data     = r_wr_data;
    assign o_rd_req      = r_rd_req;
    assign o_rd_addr     = r_rd_addr;
    assign o_frame_start = r_frame_start;
    assign o_frame_end   = r_frame_end;
    assign o_frame_err   = r_frame_err;
    assign o_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_spi_slave_regif.sv
// tb/tb_spi_slave_regif.sv - directed vector bench for spi_slave_regif in modes 0 and 3
module tb_spi_slave_regif;

    localparam int HALF = 80;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk0 = 1'b0, ss0 = 1'b1;
    logic sclk3 = 1'b1, ss3 = 1'b1;
    logic mosi = 1'b0;
    logic [7:0] rd_data = 8'h00;
    logic rd_valid = 1'b0;

    logic miso0, oe0, wr_en0, rq0, fs0, fe0, err0, busy0;
    logic [7:0] wa0, wd0, ra0;
    logic miso3, oe3, wr_en3, rq3, fs3, fe3, err3, busy3;
    logic [7:0] wa3, wd3, ra3;

    always #5 clk = ~clk;

    spi_slave_regif #(.ADDR_W(8), .DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_sclk(sclk0), .i_mosi(mosi), .i_ss(ss0),
        .o_miso(miso0), .o_miso_oe(oe0), .o_wr_en(wr_en0), .o_wr_addr(wa0), .o_wr_data(wd0),
        .o_rd_req(rq0), .o_rd_addr(ra0), .i_rd_data(rd_data), .i_rd_valid(rd_valid),
        .o_frame_start(fs0), .o_frame_end(fe0), .o_frame_err(err0), .o_busy(busy0)
    );

    spi_slave_regif #(.ADDR_W(8), .DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_sclk(sclk3), .i_mosi(mosi), .i_ss(ss3),
        .o_miso(miso3), .o_miso_oe(oe3), .o_wr_en(wr_en3), .o_wr_addr(wa3), .o_wr_data(wd3),
        .o_rd_req(rq3), .o_rd_addr(ra3), .i_rd_data(rd_data), .i_rd_valid(rd_valid),
        .o_frame_start(fs3), .o_frame_end(fe3), .o_frame_err(err3), .o_busy(busy3)
    );

    typedef struct {
        int         m;
        logic [16:0] word;
        int         nbits;
        bit         resp;
        logic [7:0] rdata;
        int         exp_wr;
        int         exp_err;
        int         exp_rq;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs[7];
    int n_chk = 0;
    int n_fail = 0;
    int n_wr[2] = '{0, 0};
    int n_err[2] = '{0, 0};
    int n_fe[2] = '{0, 0};
    int n_fs[2] = '{0, 0};
    int n_rq[2] = '{0, 0};
    int n_stray[2] = '{0, 0};
    logic [7:0] last_wa[2] = '{8'h00, 8'h00};
    logic [7:0] last_wd[2] = '{8'h00, 8'h00};
    logic cap[0:31];
    bit resp_en = 1'b0;
    logic [7:0] resp_data = 8'h00;

    // Pulse counters per DUT; wr_en and frame_err must coincide with frame_end.
    always @(negedge clk) begin
        if (wr_en0) begin n_wr[0]++; last_wa[0] = wa0; last_wd[0] = wd0; end
        if (wr_en3) begin n_wr[1]++; last_wa[1] = wa3; last_wd[1] = wd3; end
        if (err0) n_err[0]++;
        if (err3) n_err[1]++;
        if (fe0) n_fe[0]++;
        if (fe3) n_fe[1]++;
        if (fs0) n_fs[0]++;
        if (fs3) n_fs[1]++;
        if (rq0) n_rq[0]++;
        if (rq3) n_rq[1]++;
        if ((wr_en0 | err0) & ~fe0) n_stray[0]++;
        if ((wr_en3 | err3) & ~fe3) n_stray[1]++;
    end

    // Register-bank model: answer a read request three clk cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if ((rq0 | rq3) && resp_en) begin
                repeat (3) @(negedge clk);
                rd_data  = resp_data;
                rd_valid = 1'b1;
                @(negedge clk);
                rd_valid = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_sclk(input int m, input logic v);
        if (m == 0) sclk0 = v; else sclk3 = v;
    endtask

    task automatic set_ss(input int m, input logic v);
        if (m == 0) ss0 = v; else ss3 = v;
    endtask

    task automatic send_frame(input int m, input logic [16:0] word, input int nbits, input bit raise);
        @(negedge clk);
        set_ss(m, 1'b0);
        #(HALF);
        for (int k = 0; k < nbits; k++) begin
            if (m == 3) set_sclk(m, 1'b0);
            mosi = (k < 17) ? word[16-k] : 1'b0;
            #(HALF);
            cap[k] = (m == 0) ? miso0 : miso3;
            set_sclk(m, 1'b1);
            #(HALF);
            if (m == 0) set_sclk(m, 1'b0);
        end
        if (raise) begin
            set_ss(m, 1'b1);
            #(2*HALF);
        end
    endtask

    initial begin
        int x, b_wr, b_err, b_fe, b_fs, b_rq;
        logic [7:0] mb;
        logic over;

        vecs[0] = '{0, {1'b0, 8'h3C, 8'hA5}, 17, 1'b0, 8'h00, 1, 0, 0, 8'h00};
        vecs[1] = '{3, {1'b1, 8'h12, 8'h00}, 17, 1'b1, 8'h5A, 0, 0, 1, 8'h5A};
        vecs[2] = '{0, {1'b1, 8'h12, 8'h00}, 17, 1'b0, 8'h00, 0, 1, 1, 8'h00};
        vecs[3] = '{0, {1'b0, 8'h3C, 8'hA5}, 10, 1'b0, 8'h00, 0, 1, 0, 8'h00};
        vecs[4] = '{0, {1'b1, 8'h40, 8'h00}, 20, 1'b1, 8'hFF, 0, 1, 1, 8'hFF};
        vecs[5] = '{3, {1'b0, 8'h81, 8'h7E}, 17, 1'b0, 8'h00, 1, 0, 0, 8'h00};
        vecs[6] = '{0, {1'b1, 8'hC3, 8'h00}, 17, 1'b1, 8'h96, 0, 0, 1, 8'h96};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset dut0 outputs", {busy0, miso0, oe0, wr_en0, rq0, fs0, fe0, err0}, 0);
        chk("reset dut0 regs", {wa0, wd0, ra0}, 0);
        chk("reset dut3 outputs", {busy3, miso3, oe3, wr_en3, rq3, fs3, fe3, err3}, 0);
        chk("reset dut3 regs", {wa3, wd3, ra3}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("no frame_start while idle", n_fs[0] + n_fs[1], 0);

        for (int i = 0; i < 7; i++) begin
            x = (vecs[i].m == 0) ? 0 : 1;
            b_wr = n_wr[x]; b_err = n_err[x]; b_fe = n_fe[x]; b_fs = n_fs[x]; b_rq = n_rq[x];
            resp_en   = vecs[i].resp;
            resp_data = vecs[i].rdata;
            send_frame(vecs[i].m, vecs[i].word, vecs[i].nbits, 1'b1);
            chk($sformatf("v%0d frame_start count", i), n_fs[x] - b_fs, 1);
            chk($sformatf("v%0d frame_end count", i), n_fe[x] - b_fe, 1);
            chk($sformatf("v%0d frame_err count", i), n_err[x] - b_err, vecs[i].exp_err);
            chk($sformatf("v%0d wr_en count", i), n_wr[x] - b_wr, vecs[i].exp_wr);
            chk($sformatf("v%0d rd_req count", i), n_rq[x] - b_rq, vecs[i].exp_rq);
            chk($sformatf("v%0d busy after frame", i), (x == 0) ? busy0 : busy3, 0);
            if (vecs[i].exp_wr != 0) begin
                chk($sformatf("v%0d wr_addr", i), last_wa[x], vecs[i].word[15:8]);
                chk($sformatf("v%0d wr_data", i), last_wd[x], vecs[i].word[7:0]);
            end
            if (vecs[i].exp_rq != 0)
                chk($sformatf("v%0d rd_addr", i), (x == 0) ? ra0 : ra3, vecs[i].word[15:8]);
            if (vecs[i].nbits >= 17) begin
                for (int j = 0; j < 8; j++) mb[7-j] = cap[9+j];
                chk($sformatf("v%0d miso data byte", i), mb, vecs[i].exp_miso);
            end
            if (vecs[i].nbits > 17) begin
                over = 1'b0;
                for (int j = 17; j < vecs[i].nbits; j++) over = over | cap[j];
                chk($sformatf("v%0d miso after bit 17", i), over, 0);
            end
        end
        resp_en = 1'b0;

        // Reset in the middle of a data phase, then a clean write frame.
        b_wr = n_wr[0]; b_err = n_err[0]; b_fe = n_fe[0];
        send_frame(0, {1'b0, 8'h77, 8'h11}, 12, 1'b0);
        chk("mid-frame busy before reset", busy0, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid-frame reset outputs", {busy0, miso0, oe0, wr_en0, rq0, fe0, err0}, 0);
        chk("mid-frame reset regs", {wa0, wd0, ra0}, 0);
        ss0 = 1'b1;
        sclk0 = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("reset frame no frame_end", n_fe[0] - b_fe, 0);
        chk("reset frame no frame_err", n_err[0] - b_err, 0);
        chk("reset frame no wr_en", n_wr[0] - b_wr, 0);
        send_frame(0, {1'b0, 8'h55, 8'h0F}, 17, 1'b1);
        chk("post-reset wr_en count", n_wr[0] - b_wr, 1);
        chk("post-reset frame_err count", n_err[0] - b_err, 0);
        chk("post-reset wr_addr", last_wa[0], 8'h55);
        chk("post-reset wr_data", last_wd[0], 8'h0F);

        chk("dut0 strobes outside frame_end", n_stray[0], 0);
        chk("dut3 strobes outside frame_end", n_stray[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
